// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: one 64-bit limb per cycle, carry kept in a register.
// Optional signed-overflow output ovf is built when MP_ADD_OVF_FLAG_EN is defined.
module mp_add_seq #(
  parameter int LIMBS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*LIMBS-1:0]   a,
  input  logic [64*LIMBS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LIMBS-1:0]   sum,
  output logic                  cout,
`ifdef MP_ADD_OVF_FLAG_EN
  output logic                  ovf,
`endif
  output logic                  busy
);

  localparam int W  = 64 * LIMBS;
  localparam int IW = $clog2(LIMBS);

  // Handshakes: a transfer happens on an edge where valid && ready; in_ready is
  // high only in IDLE, out_valid only in DONE, and rst overrides both.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [W-1:0]   a_sh, b_sh;
  logic [63:0]    a_limb, b_limb;
  logic [64:0]    limb_sum;
  logic           last_limb;

  assign a_sh      = a_q >> {idx_q, 6'd0};
  assign b_sh      = b_q >> {idx_q, 6'd0};
  assign a_limb    = a_sh[63:0];
  assign b_limb    = b_sh[63:0];
  assign limb_sum  = {1'b0, a_limb} + {1'b0, b_limb} + {64'd0, carry_q};
  assign last_limb = (idx_q == IW'(LIMBS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < LIMBS; i++) begin
          if (idx_q == IW'(i)) sum_d[i*64 +: 64] = limb_sum[63:0];
        end
        carry_d = limb_sum[64];
        idx_d   = idx_q + 1'b1;
        if (last_limb) begin
          cout_d  = limb_sum[64];
          // Carry into the top bit is a^b^s at bit 63 of the top limb.
          ovf_d   = a_limb[63] ^ b_limb[63] ^ limb_sum[63] ^ limb_sum[64];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef MP_ADD_OVF_FLAG_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with LIMBS=4; expected results are hand-computed.
// Checks ovf as well when MP_ADD_OVF_FLAG_EN is defined.
module tb_mp_add_seq;

  localparam int LIMBS = 4;
  localparam int W     = 64 * LIMBS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, cin, out_valid, out_ready, cout, busy, ovf;
  logic [W-1:0]   a, b, sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];

  mp_add_seq #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef MP_ADD_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

`ifndef MP_ADD_OVF_FLAG_EN
  assign ovf = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait for the result, check it, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo,
                        input int stall, input bit poke);
    logic [W+1:0] exp;
    int cnt;
    exp_q.push_back({eo, ec, es});
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
      if (cnt == 1) begin
        check_eq({tag, "_busy"}, {257'd0, busy}, {257'd0, 1'b1});
        if (poke) begin
          a = ~av; b = {W{1'b1}}; cin = 1'b1; in_valid = 1'b1;
        end
      end
      if (cnt == 2) in_valid = 1'b0;
    end
    check_eq({tag, "_latency"}, (W+2)'(cnt), (W+2)'(LIMBS));
    exp = exp_q.pop_front();
    check_eq({tag, "_sum"}, {2'b00, sum}, {2'b00, exp[W-1:0]});
    check_eq({tag, "_cout"}, {257'd0, cout}, {257'd0, exp[W]});
`ifdef MP_ADD_OVF_FLAG_EN
    check_eq({tag, "_ovf"}, {257'd0, ovf}, {257'd0, exp[W+1]});
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq({tag, "_hold"}, {out_valid, in_ready, sum}, {1'b1, 1'b0, exp[W-1:0]});
      check_eq({tag, "_hold_cout"}, {257'd0, cout}, {257'd0, exp[W]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, {256'd0, in_ready, out_valid}, {256'd0, 1'b1, 1'b0});
    check_eq({tag, "_keep"}, {2'b00, sum}, {2'b00, exp[W-1:0]});
  endtask

  initial begin
    logic [W-1:0] ones, mixed_a, mixed_b, mixed_s;
    ones    = {W{1'b1}};
    mixed_a = {64'h0123456789ABCDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    mixed_b = {64'h1, 64'h0, 64'h8000_0000_0000_0000, 64'h1};
    mixed_s = {64'h0123456789ABCDF1, 64'h0, 64'h1, 64'h0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("reset_ctrl", {255'd0, in_ready, out_valid, busy}, {255'd0, 1'b1, 1'b0, 1'b0});
    check_eq("reset_res", {1'b0, ovf, sum}, '0);
    check_eq("reset_cout", {257'd0, cout}, '0);

    run_op("basic", 256'd1, 256'd2, 1'b0, 256'd3, 1'b0, 1'b0, 0, 0);
    run_op("ripple", ones, 256'd0, 1'b1, 256'd0, 1'b1, 1'b0, 0, 0);
    run_op("ovf_top", 256'd1 << 255, 256'd1 << 255, 1'b0, 256'd0, 1'b1, 1'b1, 0, 0);
    run_op("ovf_pos", 256'd1 << 254, 256'd1 << 254, 1'b0, 256'd1 << 255, 1'b0, 1'b1, 0, 0);
    run_op("mixed", mixed_a, mixed_b, 1'b0, mixed_s, 1'b0, 1'b0, 0, 0);
    run_op("backpressure", 256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0, 256'd1 << 64, 1'b0, 1'b0, 10, 0);
    run_op("ignored", 256'd10, 256'd20, 1'b0, 256'd30, 1'b0, 1'b0, 0, 1);

    // Reset during the second RUN cycle.
    a = 256'd1; b = 256'd1; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_ctrl", {255'd0, in_ready, out_valid, busy}, {255'd0, 1'b1, 1'b0, 1'b0});
    check_eq("midrst_res", {1'b0, cout, sum}, '0);
    run_op("after_rst", 256'd5, 256'd7, 1'b0, 256'd12, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter LIMBS, default 4, giving the number of 64-bit limbs per operand (legal range 2..16).
REQ-002 SHALL have ports, one per line (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept an operand set.
- a  input  64*LIMBS  operand A, limb 0 in bits [63:0].
- b  input  64*LIMBS  operand B, same layout.
- cin  input  1  carry into limb 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  64*LIMBS  registered multi-precision sum.
- cout  output  1  registered carry out of the top limb.
- busy  output  1  high in RUN.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-004 SHALL assert in_ready only in IDLE.
REQ-005 SHALL, on in_valid&&in_ready at an edge, latch a, b and cin, clear limb index idx to 0, and enter RUN.
REQ-006 SHALL, at each RUN edge:
- add limb idx of A, limb idx of B and the carry register with a 64-bit adder;
- write the 64-bit result into sum limb idx;
- load the adder carry-out into the carry register;
- increment idx.
REQ-007 SHALL, at the RUN edge with idx==LIMBS-1, load cout with that limb's carry-out and enter DONE.
REQ-008 SHALL, when an operand set is accepted at edge k, assert out_valid from after edge k+LIMBS, i.e. LIMBS cycles spent in RUN.
REQ-009 SHALL assert out_valid only in DONE and hold sum and cout stable there until out_ready is sampled high.
REQ-010 SHALL, on out_valid&&out_ready, return to IDLE; no new operand is accepted in the same cycle, so the minimum issue interval is LIMBS+2 cycles.
REQ-011 SHALL ignore in_valid while in RUN or DONE; latched operands are not disturbed.
REQ-012 SHALL compute sum+cout exactly as the (64*LIMBS+1)-bit value A+B+cin, modulo nothing.
REQ-013 SHALL leave sum and cout holding the last result in IDLE; they change only during RUN.
REQ-014 SHALL handle the carry wrap correctly: a carry into a limb that is all ones zeroes that limb and carries on to the next.

Reset
REQ-015 SHALL, when rst is high at a clock edge (in any state, including mid-RUN), force IDLE, idx=0, carry register=0, sum=0, cout=0, out_valid=0 and busy=0; in_ready SHALL be 1 in the following cycle.
REQ-016 SHALL have rst take priority over every handshake in the same cycle; a partial result SHALL never be presented.

Configuration
REQ-017 SHALL support the macro MP_ADD_OVF_FLAG_EN.
REQ-018 SHALL, when MP_ADD_OVF_FLAG_EN is defined:
- add an output port ovf (1 bit), registered with cout;
- ovf is the two's-complement signed overflow of the full-width add, i.e. the carry into the top bit XOR cout;
- ovf resets to 0 and is held in DONE and IDLE like sum.
REQ-019 SHALL, when MP_ADD_OVF_FLAG_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-020 Bench SHALL cover, with LIMBS=4:
- Basic add: A=1, B=2, cin=0 -> out_valid 4 cycles after accept; sum=3, cout=0.
- Full carry ripple: A=2^256-1, B=0, cin=1 -> sum=0, cout=1 (and ovf=0 with the macro).
- Signed overflow: A=B=2^255 -> sum=0, cout=1, ovf=1; A=B=2^254 -> sum=2^255, cout=0, ovf=1.
- Backpressure: out_ready low for 10 cycles after out_valid -> sum, cout and out_valid stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 the next cycle.
- Reset mid-RUN: rst at the second RUN cycle -> next cycle sum=0, cout=0, out_valid=0, in_ready=1; a fresh A=5, B=7 then gives sum=12.
- Ignored input: in_valid pulsed with new operands during RUN -> the result matches the originally accepted operands only.
